pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage of the single-cycle CPU. Registers the 32-bit next-PC value produced by the PC-source 2:1 mux, presents the current fetch address and PC+4 to instruction memory and the PC adder path, and gates PC updates with stall, halt/resume and misalignment-fault control. It also keeps a retired-instruction counter for bring-up and debug on the FPGA.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- next_pc  input  32  next address from the PC-source mux (PC+4 or branch/jump target).
- stall  input  1  hold PC this cycle; no retire.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- pc  output  32  current fetch address, registered.
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
- fetch_valid  output  1  high when pc is a live fetch (RUN state only).
- misaligned  output  1  sticky fault flag; next_pc[1:0] was nonzero on an accepted update.
- retired_count  output  32  count of accepted PC updates, wraps at 2^32.
- state  output  2  00 BOOT, 01 RUN, 10 HALT, 11 FAULT.

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset (rst_n low at a rising edge): pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, misaligned = 0, retired_count = 0. Reset overrides every other input and aborts any state, including FAULT.
- BOOT: lasts exactly one cycle; pc unchanged; next_pc, stall, halt_req and resume ignored; unconditional move to RUN.
- RUN, priority order each cycle:
  - halt_req = 1 -> HALT; pc held; no retire. Wins over stall and update.
  - stall = 1 -> pc held; no retire; stay in RUN.
  - next_pc[1:0] != 0 -> FAULT; pc held (the faulting target is not loaded); misaligned set; no retire.
  - otherwise pc <= next_pc; retired_count <= retired_count + 1.
- HALT: pc held; fetch_valid = 0; resume = 1 -> RUN next cycle. halt_req and resume both high -> stay in HALT. stall ignored.
- FAULT: pc held; fetch_valid = 0; misaligned stays 1; exit only via reset.
- Branch to the current pc (next_pc == pc) is a legal update and counts as a retire.
- pc wrap: next_pc = 32'hFFFF_FFFC then 32'h0000_0000 is legal; pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000.

## Timing
- pc, state, fetch_valid, misaligned and retired_count are registered; a change appears one cycle after the controlling input is sampled.
- pc_plus4 tracks pc combinationally, with zero added latency.
- After rst_n is released, the first RUN cycle (fetch_valid = 1) is the second rising edge. pc = RESET_VECTOR throughout BOOT and during the first RUN cycle.
- The first next_pc accepted is the one sampled in the first RUN cycle.
- fetch_valid = 1 exactly when state = RUN, including stalled cycles.
- halt_req: the cycle it is sampled in RUN is the last RUN cycle. resume: one cycle HALT -> RUN.
- No combinational path from any input to pc, fetch_valid, state or misaligned.

## Test plan
- Reset/boot: hold rst_n low 3 cycles, RESET_VECTOR = 32'h0000_0100, release -> pc = 0x100, state BOOT for 1 cycle then RUN, fetch_valid rises on the 2nd edge, retired_count = 0.
- Sequential run: drive next_pc = pc_plus4 for 10 cycles -> pc steps 0x100, 0x104, … 0x128, retired_count = 10. Stall on cycles 3 to 4 -> pc frozen for 2 cycles, count = 8.
- Branch and wrap: next_pc = 0xFFFF_FFFC, then pc_plus4 -> pc = 0xFFFF_FFFC then 0x0000_0000, pc_plus4 = 0x0 then 0x4, count increments by 2.
- Halt/resume: halt_req together with stall in RUN -> HALT next cycle, pc held, fetch_valid = 0. halt_req and resume both high -> remain in HALT. resume alone -> RUN; the next accepted next_pc loads.
- Misalignment: next_pc = 0x0000_0206 in RUN -> state FAULT, misaligned = 1, pc unchanged, count unchanged. Later next_pc values and resume are ignored. rst_n low for 1 cycle -> misaligned = 0, state BOOT.
- Reset mid-operation: assert rst_n low while in RUN with retired_count = 5 and pc = 0x140 -> next edge pc = RESET_VECTOR, count = 0, state BOOT.

Source files
------------

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - PC stage control inputs and fetch/status outputs.
interface pc_unit_if;
    logic [31:0] next_pc;
    logic        stall;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        misaligned;
    logic [31:0] retired_count;
    logic [1:0]  state;

    modport master (
        output next_pc, stall, halt_req, resume,
        input  pc, pc_plus4, fetch_valid, misaligned, retired_count, state
    );

    modport slave (
        input  next_pc, stall, halt_req, resume,
        output pc, pc_plus4, fetch_valid, misaligned, retired_count, state
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with stall, halt/resume, misalignment fault and retire counter.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        misaligned_q, misaligned_d;
    logic        fetch_valid_q, fetch_valid_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        retired_d    = retired_q;
        misaligned_d = misaligned_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // halt beats stall beats fault beats update
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.stall) begin
                    state_d = ST_RUN;
                end else if (bus.next_pc[1:0] != 2'b00) begin
                    state_d      = ST_FAULT;
                    misaligned_d = 1'b1;
                end else begin
                    pc_d      = bus.next_pc;
                    retired_d = retired_q + 32'd1;
                end
            end
            ST_HALT: begin
                if (bus.resume && !bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_FAULT;
        endcase
        fetch_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            retired_q     <= 32'd0;
            misaligned_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            retired_q     <= retired_d;
            misaligned_q  <= misaligned_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_q + 32'd4;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.misaligned    = misaligned_q;
    assign bus.retired_count = retired_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit.
module tb_pc_unit;
    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10, S_FAULT = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    pc_unit_if bus ();

    pc_unit #(.RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_core(input string tag, input logic [1:0] st);
        check({tag, " pc"}, bus.pc, exp_pc);
        check({tag, " pc_plus4"}, bus.pc_plus4, exp_pc + 32'd4);
        check({tag, " count"}, bus.retired_count, exp_cnt);
        check({tag, " state"}, {30'd0, bus.state}, {30'd0, st});
        check({tag, " fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, (st == S_RUN)});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.next_pc = 32'd0;
        bus.stall = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume = 1'b0;
        exp_pc = RV;
        exp_cnt = 32'd0;

        // reset and boot
        repeat (3) step();
        check_core("reset", S_BOOT);
        check("reset misaligned", {31'd0, bus.misaligned}, 32'd0);
        rst_n = 1'b1;
        bus.next_pc = 32'h0000_0abc;
        bus.halt_req = 1'b1;
        step();
        check_core("boot->run", S_RUN);
        bus.halt_req = 1'b0;

        // sequential run
        for (int i = 0; i < 10; i++) begin
            bus.next_pc = bus.pc_plus4;
            step();
            exp_pc = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            check("seq pc", bus.pc, exp_pc);
        end
        check("seq end pc", bus.pc, 32'h0000_0128);
        check("seq end count", bus.retired_count, 32'd10);

        // run with stall on cycles 3 and 4
        for (int i = 0; i < 10; i++) begin
            bus.stall = (i == 2 || i == 3);
            bus.next_pc = bus.pc_plus4;
            step();
            if (i != 2 && i != 3) begin
                exp_pc = exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
            end
            check_core("stall run", S_RUN);
        end
        bus.stall = 1'b0;
        check("stall end count", bus.retired_count, 32'd18);

        // branch to top of memory, then wrap
        bus.next_pc = 32'hFFFF_FFFC;
        step();
        exp_pc = 32'hFFFF_FFFC; exp_cnt = exp_cnt + 1;
        check_core("branch top", S_RUN);
        check("wrap plus4", bus.pc_plus4, 32'h0000_0000);
        bus.next_pc = bus.pc_plus4;
        step();
        exp_pc = 32'h0; exp_cnt = exp_cnt + 1;
        check_core("wrap", S_RUN);
        check("wrap plus4 b", bus.pc_plus4, 32'h0000_0004);

        // branch to self
        bus.next_pc = 32'h0;
        step();
        exp_cnt = exp_cnt + 1;
        check_core("self branch", S_RUN);

        // halt with stall, halt+resume, resume
        bus.next_pc = 32'h8; bus.halt_req = 1'b1; bus.stall = 1'b1;
        step();
        check_core("halt", S_HALT);
        bus.resume = 1'b1; bus.stall = 1'b0;
        step();
        check_core("halt+resume", S_HALT);
        bus.halt_req = 1'b0;
        step();
        check_core("resume", S_RUN);
        bus.resume = 1'b0;
        step();
        exp_pc = 32'h8; exp_cnt = exp_cnt + 1;
        check_core("post resume", S_RUN);

        // misaligned target
        bus.next_pc = 32'h0000_0206;
        step();
        check_core("fault", S_FAULT);
        check("fault misaligned", {31'd0, bus.misaligned}, 32'd1);
        bus.next_pc = 32'h200; bus.resume = 1'b1;
        repeat (2) step();
        check_core("fault sticky", S_FAULT);
        check("fault sticky misaligned", {31'd0, bus.misaligned}, 32'd1);
        bus.resume = 1'b0;
        rst_n = 1'b0;
        step();
        exp_pc = RV; exp_cnt = 0;
        check_core("fault reset", S_BOOT);
        check("fault reset misaligned", {31'd0, bus.misaligned}, 32'd0);
        rst_n = 1'b1;
        step();
        check_core("reboot", S_RUN);

        // reset mid-operation
        for (int i = 0; i < 5; i++) begin
            bus.next_pc = 32'h130 + 32'(4 * i);
            step();
        end
        exp_pc = 32'h140; exp_cnt = 5;
        check_core("pre reset", S_RUN);
        rst_n = 1'b0;
        step();
        exp_pc = RV; exp_cnt = 0;
        check_core("mid reset", S_BOOT);
        rst_n = 1'b1;
        step();
        check_core("mid reset boot", S_RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
